pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
Parametrised, carry-pipelined adder/subtractor. It is the successor to the fixed-width ripple, lookahead and carry-select adders in the common adder set. The WIDTH-bit operation is split into CHUNK-bit segments, and one segment is resolved per pipeline stage, with the carry registered between stages. The block accepts one operation per clock through a valid/ready handshake and stalls cleanly under backpressure, so it can sit directly in ALU and DSP datapaths.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK, minimum 1.

Ports:
clk  input  1  clock, all logic rising-edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry in; ignored when sub=1.
sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
out_valid  output  1  result beat valid.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH  result.
cout  output  1  carry out of the MSB; for sub this is "no borrow".
ovf  output  1  signed overflow: operand MSBs (after B inversion) equal and sum MSB differs.
zero  output  1  sum == 0.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - All stage valid bits clear. out_valid=0; sum, cout, ovf and zero =0.
  - Data registers need not be cleared, but outputs must read 0 while out_valid=0 after reset.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv, combinational from out_valid and out_ready.
- Transfer rules:
  - An input beat transfers on in_valid && in_ready.
  - An output beat transfers on out_valid && out_ready.
  - When adv=0, every pipeline register holds its value.
- Stage k (0..STAGES-1):
  - Adds chunk k of A and of B_eff (B_eff = sub ? ~b : b) plus the registered carry from stage k-1.
  - Stage 0 uses carry c0 = sub ? 1 : cin.
  - Result chunk and carry are registered.
- Skew and deskew:
  - Upper operand chunks are delayed by k stages through skew registers before stage k.
  - Lower result chunks are delayed through deskew registers so all chunks of one operation emerge together.
- Latency is exactly STAGES cycles from input transfer to out_valid, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput is one operation per clock while out_ready=1.
- Bubbles (in_valid=0) propagate as invalid stages. Valid bits shift with adv, and a bubble may be collapsed only by advancing; there is no compaction.
- Flags:
  - ovf and zero are computed from the final-stage values and registered together with sum and cout.
  - No flag may lead or lag its sum.
- STAGES=1: behaves as a single registered adder with latency 1.
- Ordering: results leave in input order; there is no reordering and no drop.
- Reset mid-operation: in-flight beats are discarded and out_valid is 0 on the next cycle.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.
- Wrap-around:
  - sum is modulo 2^WIDTH.
  - For example, 0xFFFFFFFF+1 gives sum=0, cout=1, zero=1, ovf=0.

Decomposition:
- Shared header `adder_defs.vh`:
  - Mode encodings ADD=1'b0 and SUB=1'b1.
  - A STAGES computation macro.
- One natural sub-module, adder_stage:
  - Parameter CHUNK; inputs a_chunk, b_chunk, c_in and en.
  - Registered s_chunk and c_out.
  - Its combinational core reuses the existing full-adder cell chain.
- Skew/deskew registers are generate loops in the top level.

Test Plan:
- WIDTH=32, CHUNK=8, out_ready=1: a=0x12345678, b=0x11111111, cin=0, sub=0 -> exactly 4 cycles later out_valid=1, sum=0x23456789, cout=0, ovf=0, zero=0.
- Carry across every chunk boundary: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, zero=1, ovf=0.
- Subtract and signed overflow:
  - a=0x80000000, b=0x00000001, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
  - a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- Back-to-back stream of 8 random beats with out_ready held 0 for cycles 6-9:
  - in_ready=0 during the stall.
  - No beat is lost or duplicated; results emerge in order and match the reference a+b+cin.
- Reset mid-operation: 3 beats in flight, rst_n=0 for 1 cycle -> next cycle out_valid=0 and all outputs 0; none of the 3 results ever appears.
- Parameter sweep (WIDTH,CHUNK) = (16,16), (16,4), (64,8) with 1000 random beats, random in_valid and random out_ready -> bit-exact sum/cout/ovf/zero against a behavioural model; latency equals STAGES when out_ready=1.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared mode encodings and stage-count helper for the pipelined adder
package pipelined_adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // number of carry-pipeline stages, never fewer than one
    function automatic int calc_stages(input int width, input int chunk);
        return ((width / chunk) < 1) ? 1 : (width / chunk);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand and result handshake bundle for the pipelined adder
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_adder_stage.sv
// rtl/pipelined_adder_stage.sv - one CHUNK-bit carry-pipeline stage with registered sum and carry
module pipelined_adder_stage #(
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [CHUNK-1:0] a_chunk_i,
    input  logic [CHUNK-1:0] b_chunk_i,
    input  logic             c_in_i,
    output logic [CHUNK-1:0] s_next_o,
    output logic [CHUNK-1:0] s_chunk_o,
    output logic             c_out_o
);
    logic [CHUNK:0]   cy;
    logic [CHUNK-1:0] s_d;
    logic [CHUNK-1:0] s_q;
    logic             c_q;

    // ripple through a chain of full-adder cells, one per bit
    always_comb begin
        cy    = '0;
        s_d   = '0;
        cy[0] = c_in_i;
        for (int i = 0; i < CHUNK; i++) begin
            s_d[i]  = a_chunk_i[i] ^ b_chunk_i[i] ^ cy[i];
            cy[i+1] = (a_chunk_i[i] & b_chunk_i[i]) | (cy[i] & (a_chunk_i[i] ^ b_chunk_i[i]));
        end
    end

    // capture the chunk result and carry only when the pipe advances
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            s_q <= s_d;
            c_q <= cy[CHUNK];
        end
    end

    assign s_next_o  = s_d;
    assign s_chunk_o = s_q;
    assign c_out_o   = c_q;
endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - carry-pipelined adder/subtractor with valid/ready flow control
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);
    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    logic                         adv;
    logic [WIDTH-1:0]             b_eff;
    logic                         c0;
    logic [STAGES-1:0]            vld_q;
    logic [STAGES-1:0]            vld_d;
    logic [STAGES-1:0][CHUNK-1:0] a_in;
    logic [STAGES-1:0][CHUNK-1:0] b_in;
    logic [STAGES-1:0][CHUNK-1:0] s_nxt;
    logic [STAGES-1:0][CHUNK-1:0] s_reg;
    logic [STAGES-1:0]            c_in;
    logic [STAGES-1:0]            carry;
    logic [STAGES-1:0]            zhit;
    logic [STAGES-1:0]            zero_q;
    logic [STAGES-1:0]            zero_d;
    logic                         ovf_q;
    logic                         ovf_d;
    logic [WIDTH-1:0]             sum_w;

    // the whole pipe moves as one; a full output that is not taken freezes everything
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign b_eff        = (bus.sub == MODE_ADD) ? bus.b : ~bus.b;
    assign c0           = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;
    assign vld_d        = (vld_q << 1) | STAGES'(bus.in_valid);

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // operand chunks k..STAGES-1 of the beat entering stage k
        logic [WIDTH-k*CHUNK-1:0] a_sk;
        logic [WIDTH-k*CHUNK-1:0] b_sk;

        if (k == 0) begin : g_head
            assign a_sk    = bus.a;
            assign b_sk    = b_eff;
            assign c_in[k] = c0;
        end else begin : g_body
            // finished lower result chunks travelling alongside the operation
            logic [k*CHUNK-1:0] lo_q;
            logic [k*CHUNK-1:0] lo_d;

            if (k == 1) begin : g_lo_first
                assign lo_d = s_reg[0];
            end else begin : g_lo_more
                assign lo_d = {s_reg[k-1], g_st[k-1].g_body.lo_q};
            end

            // skew the unresolved upper operand chunks and deskew the resolved lower ones
            always_ff @(posedge clk) begin
                if (adv) begin
                    a_sk <= g_st[k-1].a_sk[WIDTH-(k-1)*CHUNK-1:CHUNK];
                    b_sk <= g_st[k-1].b_sk[WIDTH-(k-1)*CHUNK-1:CHUNK];
                    lo_q <= lo_d;
                end
            end

            assign c_in[k] = carry[k-1];
        end

        assign a_in[k] = a_sk[CHUNK-1:0];
        assign b_in[k] = b_sk[CHUNK-1:0];
        assign zhit[k] = (s_nxt[k] == '0);

        pipelined_adder_stage #(
            .CHUNK(CHUNK)
        ) u_stage (
            .clk_i    (clk),
            .en_i     (adv),
            .a_chunk_i(a_in[k]),
            .b_chunk_i(b_in[k]),
            .c_in_i   (c_in[k]),
            .s_next_o (s_nxt[k]),
            .s_chunk_o(s_reg[k]),
            .c_out_o  (carry[k])
        );
    end

    if (STAGES == 1) begin : g_sum_single
        assign sum_w = s_reg[0];
    end else begin : g_sum_multi
        assign sum_w = {s_reg[STAGES-1], g_st[STAGES-1].g_body.lo_q};
    end

    // zero accumulates chunk by chunk so it lands in the same cycle as its sum
    assign zero_d = zhit & ((zero_q << 1) | STAGES'(1));
    assign ovf_d  = (a_in[STAGES-1][CHUNK-1] == b_in[STAGES-1][CHUNK-1]) &&
                    (s_nxt[STAGES-1][CHUNK-1] != a_in[STAGES-1][CHUNK-1]);

    // stage valid bits shift with the pipe; reset drops every in-flight beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= vld_d;
        end
    end

    // flag registers advance in lockstep with the stage data
    always_ff @(posedge clk) begin
        if (adv) begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    // data registers are not reset, so results are masked while nothing valid is presented
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = bus.out_valid ? sum_w : '0;
    assign bus.cout      = bus.out_valid && carry[STAGES-1];
    assign bus.ovf       = bus.out_valid && ovf_q;
    assign bus.zero      = bus.out_valid && zero_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for the pipelined adder
module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst_n;
    logic rst_sw_n;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(32)) bus32 ();

    pipelined_adder #(
        .WIDTH(32),
        .CHUNK(8)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus32.slave)
    );

    localparam int ND = 6;
    logic [31:0] d_a  [ND] = '{32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'd5, 32'hFFFFFFFF, 32'd10};
    logic [31:0] d_b  [ND] = '{32'h11111111, 32'h00000000, 32'h00000001, 32'd7, 32'h00000001, 32'd3};
    logic        d_c  [ND] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        d_s  [ND] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] d_es [ND] = '{32'h23456789, 32'h00000000, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h00000000, 32'h00000007};
    logic [2:0]  d_ef [ND] = '{3'b000, 3'b101, 3'b110, 3'b000, 3'b101, 3'b100};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // whole-word reference: returns {cout, ovf, zero, sum}
    function automatic logic [66:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sub, input int w);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] be;
        logic [64:0] full;
        logic [63:0] s;
        logic        co;
        logic        ov;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        be   = (sub ? ~b : b) & mask;
        full = {1'b0, am} + {1'b0, be} + (sub ? 65'd1 : 65'(cin));
        s    = full[63:0] & mask;
        co   = full[w];
        ov   = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
        return {co, ov, (s == 64'd0), s};
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = '1;
            2: r = 64'd1 << (w - 1);
            3: r = 64'd1;
            default: ;
        endcase
        return r;
    endfunction

    task automatic send_one(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                            input logic ts, output logic [31:0] s, output logic [2:0] fl,
                            output int lat);
        @(negedge clk);
        bus32.a         = ta;
        bus32.b         = tb;
        bus32.cin       = tc;
        bus32.sub       = ts;
        bus32.in_valid  = 1'b1;
        bus32.out_ready = 1'b1;
        s   = '0;
        fl  = '0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            bus32.in_valid = 1'b0;
            lat++;
            #1;
            if (bus32.out_valid) begin
                s  = bus32.sum;
                fl = {bus32.cout, bus32.ovf, bus32.zero};
                break;
            end
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int W = (g == 2) ? 64 : 16;
        localparam int C = (g == 0) ? 16 : ((g == 1) ? 4 : 8);
        localparam int S = W / C;
        logic done = 1'b0;

        pipelined_adder_if #(.WIDTH(W)) sbus ();

        pipelined_adder #(
            .WIDTH(W),
            .CHUNK(C)
        ) u_sw (
            .clk  (clk),
            .rst_n(rst_sw_n),
            .bus  (sbus.slave)
        );

        initial begin : sweep
            logic [66:0] exp_q[$];
            logic [66:0] e;
            logic [66:0] nx;
            logic [63:0] ra;
            logic [63:0] rb;
            logic        pend;
            int          sent;
            int          cyc;
            int          lat;
            sent = 0;
            cyc  = 0;
            pend = 1'b0;
            nx   = '0;
            sbus.in_valid  = 1'b0;
            sbus.a         = '0;
            sbus.b         = '0;
            sbus.cin       = 1'b0;
            sbus.sub       = 1'b0;
            sbus.out_ready = 1'b1;
            wait (rst_sw_n === 1'b1);
            while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                sbus.out_ready = ($urandom_range(0, 3) != 0);
                if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
                    ra = pick(W);
                    rb = pick(W);
                    sbus.a   = ra[W-1:0];
                    sbus.b   = rb[W-1:0];
                    sbus.cin = 1'($urandom_range(0, 1));
                    sbus.sub = 1'($urandom_range(0, 1));
                    nx   = ref_add(ra, rb, sbus.cin, sbus.sub, W);
                    pend = 1'b1;
                end
                sbus.in_valid = pend;
                #1;
                if (sbus.out_valid && sbus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq($sformatf("sw%0d_spurious", g), 64'(sbus.out_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq($sformatf("sw%0d_sum", g), 64'(sbus.sum), e[63:0]);
                        check_eq($sformatf("sw%0d_flags", g),
                                 64'({sbus.cout, sbus.ovf, sbus.zero}), 64'(e[66:64]));
                    end
                end
                if (sbus.in_valid && sbus.in_ready) begin
                    exp_q.push_back(nx);
                    pend = 1'b0;
                    sent++;
                end
            end
            check_eq($sformatf("sw%0d_sent", g), 64'(sent), 64'd1000);
            check_eq($sformatf("sw%0d_left", g), 64'(exp_q.size()), 64'd0);

            @(negedge clk);
            ra = pick(W);
            rb = pick(W);
            sbus.a         = ra[W-1:0];
            sbus.b         = rb[W-1:0];
            sbus.cin       = 1'b1;
            sbus.sub       = 1'b0;
            sbus.in_valid  = 1'b1;
            sbus.out_ready = 1'b1;
            e = ref_add(ra, rb, 1'b1, 1'b0, W);
            #1;
            check_eq($sformatf("sw%0d_in_ready", g), 64'(sbus.in_ready), 64'd1);
            lat = 0;
            while (lat < 20) begin
                @(negedge clk);
                sbus.in_valid = 1'b0;
                lat++;
                #1;
                if (sbus.out_valid) break;
            end
            check_eq($sformatf("sw%0d_latency", g), 64'(lat), 64'(S));
            check_eq($sformatf("sw%0d_lat_sum", g), 64'(sbus.sum), e[63:0]);
            done = 1'b1;
        end
    end

    initial begin : main
        logic [66:0] exp_q[$];
        logic [66:0] e;
        logic [66:0] nx;
        logic [31:0] s;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  fl;
        logic        rc;
        logic        pend;
        int          lat;
        int          sent;
        int          nout;
        int          cyc;
        rst_n    = 1'b0;
        rst_sw_n = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.a         = '0;
        bus32.b         = '0;
        bus32.cin       = 1'b0;
        bus32.sub       = 1'b0;
        bus32.out_ready = 1'b0;
        nx = '0;
        repeat (3) @(negedge clk);
        rst_sw_n = 1'b1;
        #1;
        check_eq("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check_eq("rst_sum", 64'(bus32.sum), 64'd0);
        check_eq("rst_flags", 64'({bus32.cout, bus32.ovf, bus32.zero}), 64'd0);
        check_eq("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        rst_n = 1'b1;

        for (int i = 0; i < ND; i++) begin
            send_one(d_a[i], d_b[i], d_c[i], d_s[i], s, fl, lat);
            check_eq($sformatf("dir%0d_latency", i), 64'(lat), 64'd4);
            check_eq($sformatf("dir%0d_sum", i), 64'(s), 64'(d_es[i]));
            check_eq($sformatf("dir%0d_flags", i), 64'(fl), 64'(d_ef[i]));
        end

        cyc  = 0;
        sent = 0;
        nout = 0;
        pend = 1'b0;
        while ((sent < 8 || exp_q.size() != 0) && cyc < 80) begin
            @(negedge clk);
            bus32.out_ready = !(cyc >= 6 && cyc <= 9);
            if (!pend && sent < 8) begin
                ra = $urandom();
                rb = $urandom();
                rc = 1'($urandom_range(0, 1));
                bus32.a   = ra;
                bus32.b   = rb;
                bus32.cin = rc;
                bus32.sub = 1'b0;
                nx   = ref_add(64'(ra), 64'(rb), rc, 1'b0, 32);
                pend = 1'b1;
            end
            bus32.in_valid = pend;
            #1;
            if (cyc >= 6 && cyc <= 9) begin
                check_eq("stall_in_ready", 64'(bus32.in_ready), 64'd0);
            end
            if (bus32.out_valid && bus32.out_ready) begin
                nout++;
                if (exp_q.size() == 0) begin
                    check_eq("stream_spurious", 64'(bus32.out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("stream_sum", 64'(bus32.sum), e[63:0]);
                    check_eq("stream_flags", 64'({bus32.cout, bus32.ovf, bus32.zero}), 64'(e[66:64]));
                end
            end
            if (bus32.in_valid && bus32.in_ready) begin
                exp_q.push_back(nx);
                pend = 1'b0;
                sent++;
            end
            cyc++;
        end
        check_eq("stream_count", 64'(nout), 64'd8);
        check_eq("stream_left", 64'(exp_q.size()), 64'd0);

        bus32.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus32.a        = $urandom();
            bus32.b        = $urandom();
            bus32.cin      = 1'b0;
            bus32.sub      = 1'b0;
            bus32.in_valid = 1'b1;
        end
        @(negedge clk);
        bus32.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rstmid_out_valid", 64'(bus32.out_valid), 64'd0);
        check_eq("rstmid_sum", 64'(bus32.sum), 64'd0);
        check_eq("rstmid_flags", 64'({bus32.cout, bus32.ovf, bus32.zero}), 64'd0);
        rst_n = 1'b1;
        nout = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (bus32.out_valid) nout++;
        end
        check_eq("rstmid_ghosts", 64'(nout), 64'd0);
        check_eq("rstmid_in_ready", 64'(bus32.in_ready), 64'd1);

        cyc = 0;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("sweep_done", 64'({g_sw[2].done, g_sw[1].done, g_sw[0].done}), 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
